// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the three writeback requesters and the arbiter.
// The master side is the set of requesters (ALU, LSU, MUL/DIV) and also
// observes the registered register-file write port. The slave side is the
// arbiter itself.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [5*NREQ-1:0]  req_addr;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               reg_we;
    logic [4:0]         w_addr;
    logic [31:0]        w_data;
    logic               starve;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready,
        input  reg_we,
        input  w_addr,
        input  w_data,
        input  starve
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready,
        output reg_we,
        output w_addr,
        output w_data,
        output starve
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Shares the single register-file write port between req 0 (ALU),
// req 1 (LSU load return) and req 2 (MUL/DIV). Fixed priority 0 > 1 > 2
// until any requester has waited STARVE_LIMIT cycles; then round-robin
// from rr_ptr until every wait counter is back below the limit.
// The winning write is registered and drives reg_we / w_addr / w_data
// one cycle after acceptance. Writes to r0 are accepted but suppressed.
// Optional feature: define WB_BYPASS_EN to add two forwarding read ports
// that expose the write being committed this cycle to the decode stage.
module regfile_wb_arbiter #(
    parameter int NREQ         = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave bus
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]          fwd_addr0,
    input  logic [4:0]          fwd_addr1,
    output logic                fwd_hit0,
    output logic                fwd_hit1,
    output logic [31:0]         fwd_data0,
    output logic [31:0]         fwd_data1
`endif
);

    localparam logic [3:0] WAIT_MAX = 4'd15;
    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

    typedef enum logic {
        MODE_NORMAL = 1'b0,
        MODE_STARVE = 1'b1
    } mode_t;

    // Arbitration state
    mode_t                 mode_q;
    mode_t                 mode_d;
    logic [1:0]            rr_ptr_q;
    logic [1:0]            rr_ptr_d;
    logic [NREQ-1:0][3:0]  wait_q;
    logic [NREQ-1:0][3:0]  wait_d;
    logic [NREQ-1:0]       over_lim;

    // Grant stage (combinational, same cycle as the request)
    logic [NREQ-1:0]       grant_p0;
    logic                  vld_p0;
    logic                  we_p0;
    logic [4:0]            addr_p0;
    logic [31:0]           data_p0;

    // Register-file write stage
    logic                  we_p1;
    logic [4:0]            addr_p1;
    logic [31:0]           data_p1;

    // Wait counters stop at 15 so a long stall never wraps back to zero.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        if (cnt == WAIT_MAX) begin
            return WAIT_MAX;
        end
        return cnt + 4'd1;
    endfunction

    // Lowest index wins.
    function automatic logic [2:0] fixed_pick(input logic [2:0] valid);
        logic [2:0] g;
        g = 3'b000;
        if (valid[0]) begin
            g = 3'b001;
        end else if (valid[1]) begin
            g = 3'b010;
        end else if (valid[2]) begin
            g = 3'b100;
        end
        return g;
    endfunction

    // First valid requester at or after ptr, wrapping 2 -> 0.
    function automatic logic [2:0] rr_pick(input logic [2:0] valid,
                                           input logic [1:0] ptr);
        logic [2:0] g;
        g = 3'b000;
        case (ptr)
            2'd0: begin
                if (valid[0])      g = 3'b001;
                else if (valid[1]) g = 3'b010;
                else if (valid[2]) g = 3'b100;
            end
            2'd1: begin
                if (valid[1])      g = 3'b010;
                else if (valid[2]) g = 3'b100;
                else if (valid[0]) g = 3'b001;
            end
            default: begin
                if (valid[2])      g = 3'b100;
                else if (valid[0]) g = 3'b001;
                else if (valid[1]) g = 3'b010;
            end
        endcase
        return g;
    endfunction

    // Grant selection: nothing is accepted while in reset; policy follows the registered mode.
    always_comb begin
        grant_p0 = '0;
        if (!rst) begin
            if (mode_q == MODE_STARVE) begin
                grant_p0 = rr_pick(bus.req_valid, rr_ptr_q);
            end else begin
                grant_p0 = fixed_pick(bus.req_valid);
            end
        end
    end

    assign vld_p0        = |grant_p0;
    assign bus.req_ready = grant_p0;

    // Per-requester wait tracking: count while waiting, clear when served or idle.
    for (genvar i = 0; i < NREQ; i++) begin : g_wait
        assign wait_d[i]   = (bus.req_valid[i] && !grant_p0[i]) ? sat_inc(wait_q[i]) : 4'd0;
        assign over_lim[i] = (wait_d[i] >= LIMIT);
    end

    // Wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    // Mode next-state: starvation mode holds exactly while some updated counter is at or over the limit.
    always_comb begin
        mode_d = mode_q;
        if (|over_lim) begin
            mode_d = MODE_STARVE;
        end else begin
            mode_d = MODE_NORMAL;
        end
    end

    // Mode state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_NORMAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign bus.starve = (mode_q == MODE_STARVE);

    // Round-robin pointer advances past whoever was just served, in either mode.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        case (grant_p0)
            3'b001:  rr_ptr_d = 2'd1;
            3'b010:  rr_ptr_d = 2'd2;
            3'b100:  rr_ptr_d = 2'd0;
            default: rr_ptr_d = rr_ptr_q;
        endcase
    end

    // Round-robin pointer register; starts at req 1 so req 0 is not favoured first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 2'd1;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Write-port mux: select the granted requester's address and data.
    always_comb begin
        addr_p0 = bus.req_addr[4:0];
        data_p0 = bus.req_data[31:0];
        case (grant_p0)
            3'b010: begin
                addr_p0 = bus.req_addr[9:5];
                data_p0 = bus.req_data[63:32];
            end
            3'b100: begin
                addr_p0 = bus.req_addr[14:10];
                data_p0 = bus.req_data[95:64];
            end
            default: begin
                addr_p0 = bus.req_addr[4:0];
                data_p0 = bus.req_data[31:0];
            end
        endcase
    end

    assign we_p0 = vld_p0 && (addr_p0 != 5'd0);

    // ---- stage boundary: grant (p0) -> register-file write port (p1) ----
    // Write-port register: address/data hold when idle, enable drops; reset kills any in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_p1   <= 1'b0;
            addr_p1 <= 5'd0;
            data_p1 <= 32'd0;
        end else begin
            we_p1 <= we_p0;
            if (vld_p0) begin
                addr_p1 <= addr_p0;
                data_p1 <= data_p0;
            end
        end
    end

    assign bus.reg_we = we_p1;
    assign bus.w_addr = addr_p1;
    assign bus.w_data = data_p1;

`ifdef WB_BYPASS_EN
    // r0 never forwards; the write enable already excludes it, the address test keeps that explicit.
    assign fwd_hit0  = we_p1 && (addr_p1 == fwd_addr0) && (fwd_addr0 != 5'd0);
    assign fwd_hit1  = we_p1 && (addr_p1 == fwd_addr1) && (fwd_addr1 != 5'd0);
    assign fwd_data0 = fwd_hit0 ? data_p1 : 32'd0;
    assign fwd_data1 = fwd_hit1 ? data_p1 : 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed literal cases followed by a long
// randomized run compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        trst;
    logic [2:0]  tv;
    logic [4:0]  ta [3];
    logic [31:0] td [3];

    int checks;
    int errors;
    bit chk_en;

    // Behavioural model state
    int          m_wt [3];
    bit          m_starve;
    int          m_rr;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          last_g;

    int          cmp_g;
    logic [2:0]  cmp_er;

    regfile_wb_arbiter_if #(.NREQ(3)) bus ();

    assign bus.req_valid = tv;
    assign bus.req_addr  = {ta[2], ta[1], ta[0]};
    assign bus.req_data  = {td[2], td[1], td[0]};

`ifdef WB_BYPASS_EN
    logic [4:0]  fa0, fa1;
    logic        fh0, fh1;
    logic [31:0] fd0, fd1;

    regfile_wb_arbiter #(.NREQ(3), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(trst), .bus(bus),
        .fwd_addr0(fa0), .fwd_addr1(fa1),
        .fwd_hit0(fh0), .fwd_hit1(fh1),
        .fwd_data0(fd0), .fwd_data1(fd1)
    );
`else
    regfile_wb_arbiter #(.NREQ(3), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(trst), .bus(bus)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 3; i++) m_wt[i] = 0;
        m_starve = 0;
        m_rr     = 1;
        m_we     = 1'b0;
        m_addr   = 5'd0;
        m_data   = 32'd0;
    endtask

    // Which requester the rules pick right now, -1 if none.
    function automatic int m_pick(input logic [2:0] v);
        if (m_starve) begin
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = (m_rr + k) % 3;
                if (v[idx]) return idx;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (v[k]) return k;
            end
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic m_step();
        int g;
        bit any;
        if (trst) begin
            m_reset();
            last_g = -1;
        end else begin
            g = m_pick(tv);
            last_g = g;
            for (int i = 0; i < 3; i++) begin
                if (tv[i] && g != i) m_wt[i] = (m_wt[i] >= 15) ? 15 : m_wt[i] + 1;
                else                 m_wt[i] = 0;
            end
            if (g >= 0) begin
                m_addr = ta[g];
                m_data = td[g];
                m_we   = (ta[g] != 5'd0);
                m_rr   = (g + 1) % 3;
            end else begin
                m_we = 1'b0;
            end
            any = 0;
            for (int i = 0; i < 3; i++) if (m_wt[i] >= LIMIT) any = 1;
            m_starve = any;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_g  = m_pick(tv);
            cmp_er = (trst || cmp_g < 0) ? 3'b000 : 3'(1 << cmp_g);
            chk("model_ready",  32'(bus.req_ready), 32'(cmp_er));
            chk("model_reg_we", 32'(bus.reg_we),    32'(m_we));
            chk("model_w_addr", 32'(bus.w_addr),    32'(m_addr));
            chk("model_w_data", bus.w_data,         m_data);
            chk("model_starve", 32'(bus.starve),    32'(m_starve));
        end
    end

    logic [2:0] seq4 [7];
    bit         st4  [7];
    logic [2:0] seq6 [5];

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 0;
        last_g = -1;
        trst   = 1'b1;
        tv     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            ta[i] = 5'd0;
            td[i] = 32'd0;
        end
`ifdef WB_BYPASS_EN
        fa0 = 5'd0;
        fa1 = 5'd0;
`endif
        m_reset();
        seq4 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b001};
        st4  = '{0, 0, 0, 0, 1, 1, 0};
        seq6 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010};

        tick();
        chk_en = 1;
        tick();
        trst = 1'b0;

        // Reset then idle
        tick();
        settle();
        chk("idle_we",    32'(bus.reg_we),    32'd0);
        chk("idle_addr",  32'(bus.w_addr),    32'd0);
        chk("idle_data",  bus.w_data,         32'd0);
        chk("idle_ready", 32'(bus.req_ready), 32'd0);
        chk("idle_starve", 32'(bus.starve),   32'd0);

        // Single LSU write
        tv = 3'b010; ta[1] = 5'd5; td[1] = 32'hDEADBEEF;
        settle();
        chk("single_ready", 32'(bus.req_ready), 32'b010);
        tick();
        tv = 3'b000;
        settle();
        chk("single_we",   32'(bus.reg_we), 32'd1);
        chk("single_addr", 32'(bus.w_addr), 32'd5);
        chk("single_data", bus.w_data,      32'hDEADBEEF);

        // ALU and MUL/DIV together
        tv = 3'b101; ta[0] = 5'd3; td[0] = 32'h0000_0333; ta[2] = 5'd7; td[2] = 32'h0000_0777;
        settle();
        chk("pair_ready0", 32'(bus.req_ready), 32'b001);
        tick();
        tv[0] = 1'b0;
        settle();
        chk("pair_ready2", 32'(bus.req_ready), 32'b100);
        chk("pair_addr3",  32'(bus.w_addr),    32'd3);
        tick();
        tv = 3'b000;
        settle();
        chk("pair_addr7",  32'(bus.w_addr),    32'd7);
        chk("pair_data7",  bus.w_data,         32'h0000_0777);
        tick();

        // All three continuously valid: starvation kicks in after four req0 grants
        tv = 3'b111;
        ta[0] = 5'd1; td[0] = 32'hA0A0_0001;
        ta[1] = 5'd2; td[1] = 32'hB0B0_0002;
        ta[2] = 5'd4; td[2] = 32'hC0C0_0004;
        for (int k = 0; k < 7; k++) begin
            settle();
            chk("starve_seq_ready", 32'(bus.req_ready), 32'(seq4[k]));
            chk("starve_seq_flag",  32'(bus.starve),    32'(st4[k]));
            tick();
        end
        tv = 3'b000;
        tick();
        tick();
        settle();
        chk("starve_cleared", 32'(bus.starve), 32'd0);

        // Write to r0 is accepted but suppressed
        tv = 3'b100; ta[2] = 5'd0; td[2] = 32'h12345678;
        settle();
        chk("r0_ready", 32'(bus.req_ready), 32'b100);
        tick();
        tv = 3'b000;
        settle();
        chk("r0_we",   32'(bus.reg_we), 32'd0);
        chk("r0_data", bus.w_data,      32'h12345678);
        tick();

        // Build up waits, register a write to r9, then reset mid-operation
        tv = 3'b111;
        ta[0] = 5'd9;  td[0] = 32'hCAFEF00D;
        ta[1] = 5'd10; td[1] = 32'h0000_1010;
        ta[2] = 5'd11; td[2] = 32'h0000_1111;
        tick();
        tick();
        tick();
        settle();
        chk("pre_rst_we",   32'(bus.reg_we), 32'd1);
        chk("pre_rst_addr", 32'(bus.w_addr), 32'd9);
`ifdef WB_BYPASS_EN
        fa0 = 5'd9; fa1 = 5'd4;
        #1;
        chk("fwd_hit0",  32'(fh0), 32'd1);
        chk("fwd_data0", fd0,      32'hCAFEF00D);
        chk("fwd_hit1",  32'(fh1), 32'd0);
        chk("fwd_data1", fd1,      32'd0);
        fa0 = 5'd0;
        #1;
        chk("fwd_hit0_r0",  32'(fh0), 32'd0);
        chk("fwd_data0_r0", fd0,      32'd0);
`endif
        trst = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        settle();
        chk("rst_we",     32'(bus.reg_we), 32'd0);
        chk("rst_addr",   32'(bus.w_addr), 32'd0);
        chk("rst_starve", 32'(bus.starve), 32'd0);
        trst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("post_rst_ready", 32'(bus.req_ready), 32'(seq6[k]));
            tick();
        end
        tv = 3'b000;
        tick();
        tick();

        // Randomized traffic: requesters hold until accepted, occasionally abandon, occasional reset
        for (int n = 0; n < 4000; n++) begin
            tick();
            trst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 3; i++) begin
                if (!(tv[i] && last_g != i && $urandom_range(0, 19) != 0)) begin
                    tv[i] = ($urandom_range(0, 99) < 75);
                    ta[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    td[i] = $urandom;
                end
            end
        end
        trst = 1'b0;
        tv = 3'b000;
        tick();
        tick();
        chk_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
